// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: write pointers, memory write strobe,
// and look-ahead full / almost-full / fill-count / sticky-overflow flags.
module fifo_wr_ctrl #(
    parameter int unsigned ADD_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_inc,
    input  logic                 wr_ovf_clr,
    input  logic [ADD_WIDTH:0]   rd_ptr,
    output logic                 wr_en,
    output logic [ADD_WIDTH-1:0] wr_addr,
    output logic [ADD_WIDTH:0]   wr_ptr,
    output logic                 wr_full,
    output logic                 wr_afull,
    output logic [ADD_WIDTH:0]   wr_count,
    output logic                 wr_ovf
);

    localparam int unsigned PW = ADD_WIDTH + 1;
    localparam logic [ADD_WIDTH:0] AFULL_LIM = PW'(AFULL_THRESH);

    logic [ADD_WIDTH:0] wr_bin;
    logic [ADD_WIDTH:0] bin_next;
    logic [ADD_WIDTH:0] gray_next;
    logic [ADD_WIDTH:0] rd_bin;
    logic [ADD_WIDTH:0] count_next;
    logic [ADD_WIDTH:0] full_gray;
    logic               full_next;
    logic               afull_next;

    assign wr_en   = wr_inc & ~wr_full;
    assign wr_addr = wr_bin[ADD_WIDTH-1:0];

    // Gray-to-binary of the synchronised read pointer (XOR prefix from the MSB down)
    always_comb begin
        rd_bin            = '0;
        rd_bin[ADD_WIDTH] = rd_ptr[ADD_WIDTH];
        for (int i = int'(ADD_WIDTH) - 1; i >= 0; i--) begin
            rd_bin[i] = rd_bin[i+1] ^ rd_ptr[i];
        end
    end

    // Next-state view including this cycle's write, so full asserts with the last write
    always_comb begin
        bin_next   = wr_bin + PW'(wr_en);
        gray_next  = (bin_next >> 1) ^ bin_next;
        full_gray  = {~rd_ptr[ADD_WIDTH:ADD_WIDTH-1], rd_ptr[ADD_WIDTH-2:0]};
        full_next  = (gray_next == full_gray);
        count_next = bin_next - rd_bin;
        afull_next = (count_next >= AFULL_LIM);
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_bin   <= '0;
            wr_ptr   <= '0;
            wr_full  <= 1'b0;
            wr_afull <= 1'b0;
            wr_count <= '0;
            wr_ovf   <= 1'b0;
        end else begin
            wr_bin   <= bin_next;
            wr_ptr   <= gray_next;
            wr_full  <= full_next;
            wr_afull <= afull_next;
            wr_count <= count_next;
            // A rejected write outranks a simultaneous clear
            if (wr_inc && wr_full) begin
                wr_ovf <= 1'b1;
            end else if (wr_ovf_clr) begin
                wr_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed and randomised checks of fifo_wr_ctrl with ADD_WIDTH=4, AFULL_THRESH=12.
module tb_fifo_wr_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst = 1'b0;
    logic       wr_inc = 1'b0;
    logic       wr_ovf_clr = 1'b0;
    logic [4:0] rd_ptr = '0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr;
    logic       wr_full;
    logic       wr_afull;
    logic [4:0] wr_count;
    logic       wr_ovf;

    int checks = 0;
    int errors = 0;

    // model state: absolute write count, presented read count, true read count
    int wb, rb, rt;
    logic exp_full;

    fifo_wr_ctrl #(.ADD_WIDTH(4), .AFULL_THRESH(12)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_inc(wr_inc), .wr_ovf_clr(wr_ovf_clr),
        .rd_ptr(rd_ptr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ptr(wr_ptr),
        .wr_full(wr_full), .wr_afull(wr_afull), .wr_count(wr_count), .wr_ovf(wr_ovf)
    );

    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst = 1'b1; wr_inc = 1'b0; wr_ovf_clr = 1'b0; rd_ptr = '0;
        step();
        wr_rst = 1'b0;
        wb = 0; rb = 0; rt = 0; exp_full = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wr_ptr, wr_addr, wr_count, wr_full, wr_afull, wr_ovf} !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0",
                     {wr_ptr, wr_addr, wr_count, wr_full, wr_afull, wr_ovf});
        end
    endtask

    task automatic test_fill();
        do_reset();
        wr_inc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            checks++;
            if (wr_en !== 1'b1) begin errors++; $display("FAIL fill_en[%0d]: got %b required 1", i, wr_en); end
            step();
            checks++;
            if (wr_count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d required %0d", i, wr_count, i); end
            checks++;
            if (wr_afull !== (i >= 12)) begin errors++; $display("FAIL fill_afull[%0d]: got %b required %b", i, wr_afull, i >= 12); end
            checks++;
            if (wr_full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b required %b", i, wr_full, i == 16); end
        end
        wr_inc = 1'b0;
        checks++;
        if (wr_ptr !== 5'b11000) begin errors++; $display("FAIL fill_ptr: got %b required 11000", wr_ptr); end
        checks++;
        if (wr_addr !== 4'd0) begin errors++; $display("FAIL fill_addr: got %0d required 0", wr_addr); end
    endtask

    task automatic test_overflow();
        wr_inc = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL ovf_en: got %b required 0", wr_en); end
        step();
        wr_inc = 1'b0;
        checks++;
        if ({wr_ptr, wr_count, wr_ovf} !== {5'b11000, 5'd16, 1'b1}) begin
            errors++; $display("FAIL ovf_set: got ptr=%b cnt=%0d ovf=%b required 11000/16/1", wr_ptr, wr_count, wr_ovf);
        end
        step();
        checks++;
        if (wr_ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b required 1", wr_ovf); end
        wr_ovf_clr = 1'b1;
        step();
        wr_ovf_clr = 1'b0;
        checks++;
        if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", wr_ovf); end
        wr_inc = 1'b1; wr_ovf_clr = 1'b1;
        step();
        wr_inc = 1'b0; wr_ovf_clr = 1'b0;
        checks++;
        if (wr_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b required 1", wr_ovf); end
        wr_ovf_clr = 1'b1;
        step();
        wr_ovf_clr = 1'b0;
        checks++;
        if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr2: got %b required 0", wr_ovf); end
    endtask

    task automatic test_release();
        rd_ptr = 5'b00001;
        step();
        checks++;
        if ({wr_full, wr_count} !== {1'b0, 5'd15}) begin
            errors++; $display("FAIL release_free: got full=%b cnt=%0d required 0/15", wr_full, wr_count);
        end
        wr_inc = 1'b1;
        step();
        wr_inc = 1'b0;
        checks++;
        if ({wr_full, wr_count, wr_afull} !== {1'b1, 5'd16, 1'b1}) begin
            errors++; $display("FAIL release_refill: got full=%b cnt=%0d afull=%b required 1/16/1", wr_full, wr_count, wr_afull);
        end
    endtask

    task automatic test_reset_mid();
        wr_inc = 1'b1;
        step();
        checks++;
        if (wr_ovf !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ovf: got %b required 1", wr_ovf); end
        wr_rst = 1'b1;
        step();
        wr_rst = 1'b0; wr_inc = 1'b0;
        checks++;
        if ({wr_ptr, wr_addr, wr_count, wr_full, wr_afull, wr_ovf} !== 17'h0) begin
            errors++; $display("FAIL rstmid_full: got %h required 0", {wr_ptr, wr_addr, wr_count, wr_full, wr_afull, wr_ovf});
        end
        rd_ptr = '0;
        wr_inc = 1'b1;
        repeat (5) step();
        checks++;
        if ({wr_ptr, wr_count} !== {5'b00111, 5'd5}) begin
            errors++; $display("FAIL rstmid_five: got ptr=%b cnt=%0d required 00111/5", wr_ptr, wr_count);
        end
        wr_rst = 1'b1;
        step();
        wr_rst = 1'b0; wr_inc = 1'b0;
        checks++;
        if ({wr_ptr, wr_addr, wr_count, wr_full, wr_afull, wr_ovf} !== 17'h0) begin
            errors++; $display("FAIL rstmid_zero: got %h required 0", {wr_ptr, wr_addr, wr_count, wr_full, wr_afull, wr_ovf});
        end
    endtask

    task automatic test_wrap();
        logic exp_en, saw_addr, saw_ptr;
        logic [4:0] prev_ptr;
        logic [3:0] prev_addr;
        int exp_cnt;
        do_reset();
        saw_addr = 1'b0; saw_ptr = 1'b0;
        for (int i = 0; i < 200 && wb < 40; i++) begin
            wr_inc = 1'b1;
            rd_ptr = gray(rb);
            #1;
            exp_en = !exp_full;
            checks++;
            if (wr_en !== exp_en) begin errors++; $display("FAIL wrap_en[%0d]: got %b required %b", i, wr_en, exp_en); end
            prev_ptr = wr_ptr; prev_addr = wr_addr;
            step();
            if (exp_en) wb++;
            exp_cnt = wb - rb;
            exp_full = (exp_cnt == 16);
            checks++;
            if (wr_count !== 5'(exp_cnt)) begin errors++; $display("FAIL wrap_count[%0d]: got %0d required %0d", i, wr_count, exp_cnt); end
            checks++;
            if (wr_ptr !== gray(wb)) begin errors++; $display("FAIL wrap_ptr[%0d]: got %b required %b", i, wr_ptr, gray(wb)); end
            checks++;
            if ($countones(prev_ptr ^ wr_ptr) != (exp_en ? 1 : 0)) begin
                errors++; $display("FAIL wrap_onebit[%0d]: got %b -> %b", i, prev_ptr, wr_ptr);
            end
            if (prev_addr == 4'd15 && wr_addr == 4'd0) saw_addr = 1'b1;
            if (prev_ptr == 5'b10000 && wr_ptr == 5'b00000) saw_ptr = 1'b1;
            if (i >= 2 && rb < wb) rb++;
        end
        wr_inc = 1'b0;
        checks++;
        if (wb != 40) begin errors++; $display("FAIL wrap_budget: got %0d writes required 40", wb); end
        checks++;
        if (!(saw_addr && saw_ptr)) begin
            errors++; $display("FAIL wrap_seen: got addr_wrap=%b ptr_wrap=%b required 1/1", saw_addr, saw_ptr);
        end
    endtask

    task automatic test_random();
        int h0, h1, h2, exp_cnt;
        logic exp_en, rd_go;
        do_reset();
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < 600; i++) begin
            wr_inc = ($urandom_range(0, 3) != 0);
            rb = h2;
            rd_ptr = gray(rb);
            rd_go = ($urandom_range(0, 1) == 1) && (wb - rt > 0);
            #1;
            exp_en = wr_inc && !exp_full;
            checks++;
            if (wr_en !== exp_en) begin errors++; $display("FAIL rand_en[%0d]: got %b required %b", i, wr_en, exp_en); end
            checks++;
            if (wr_en && (wb - rt >= 16)) begin errors++; $display("FAIL rand_accept_full[%0d]: true count %0d", i, wb - rt); end
            step();
            if (exp_en) wb++;
            if (rd_go) rt++;
            exp_cnt = wb - rb;
            exp_full = (exp_cnt == 16);
            checks++;
            if ({wr_count, wr_full, wr_afull} !== {5'(exp_cnt), exp_full, exp_cnt >= 12}) begin
                errors++; $display("FAIL rand_flags[%0d]: got cnt=%0d full=%b afull=%b required %0d/%b/%b",
                                   i, wr_count, wr_full, wr_afull, exp_cnt, exp_full, exp_cnt >= 12);
            end
            checks++;
            if (int'(wr_count) < wb - rt) begin errors++; $display("FAIL rand_pessimism[%0d]: got %0d true %0d", i, wr_count, wb - rt); end
            h2 = h1; h1 = h0; h0 = rt;
        end
        wr_inc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
